// File: rtl/user_input_ctrl_if.sv
// Front-panel bundle: raw pushbuttons in, image/blend state and change strobes out.
interface user_input_ctrl_if #(
  parameter int IDX_W   = 4,
  parameter int BLEND_W = 8
);
  logic               btnc;
  logic               btnl;
  logic               btnu;
  logic               btnd;
  logic [IDX_W-1:0]   image_index;
  logic [BLEND_W-1:0] blend_factor;
  logic               image_changed;
  logic               blend_changed;

  modport master (
    output btnc, btnl, btnu, btnd,
    input  image_index, blend_factor, image_changed, blend_changed
  );

  modport slave (
    input  btnc, btnl, btnu, btnd,
    output image_index, blend_factor, image_changed, blend_changed
  );
endinterface

// File: rtl/user_input_ctrl.sv
// Pushbutton debounce, wrapping image select and saturating blend control with change strobes.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the blend up/down buttons.
module user_input_ctrl #(
  parameter int N_IMAGES        = 16,
  parameter int BLEND_W         = 8,
  parameter int BLEND_STEP      = 1,
  parameter int BLEND_INIT      = 128,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  user_input_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(N_IMAGES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam logic [DB_W-1:0]          DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(N_IMAGES - 1);
  localparam logic [BLEND_W-1:0]       BLEND_MAX = '1;
  localparam logic signed [BLEND_W+1:0] STEP_S   = (BLEND_W+2)'(BLEND_STEP);

  if (N_IMAGES < 2 || BLEND_STEP < 1 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("user_input_ctrl: illegal parameter set");
  end

  // Clamp a signed, two-bit-extended blend result into 0..BLEND_MAX.
  function automatic logic [BLEND_W-1:0] sat_blend(input logic signed [BLEND_W+1:0] v);
    if (v[BLEND_W+1])    return '0;
    else if (v[BLEND_W]) return BLEND_MAX;
    else                 return v[BLEND_W-1:0];
  endfunction

  logic [3:0]      raw;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      deb;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];
  logic            up_evt;
  logic            down_evt;

  assign raw = {bus.btnd, bus.btnu, bus.btnl, bus.btnc};

  // Stage p0/p1: two-flop synchroniser; then one debounce counter per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle in which the debounced level is about to rise.
  always_comb begin
    for (int i = 0; i < 4; i++)
      press[i] = sync_p1[i] && !deb[i] && (db_cnt[i] == DB_LAST);
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  logic [1:0]      rep_state [2];
  logic [RP_W-1:0] rep_cnt   [2];
  logic [1:0]      rep_evt;

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rep_evt[j] = 1'b0;
      if (deb[BTN_U+j]) begin
        if (rep_state[j] == ST_WAIT)        rep_evt[j] = (rep_cnt[j] == DELAY_LAST);
        else if (rep_state[j] == ST_REPEAT) rep_evt[j] = (rep_cnt[j] == RATE_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        rep_state[j] <= ST_IDLE;
        rep_cnt[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        case (rep_state[j])
          ST_IDLE: begin
            if (press[BTN_U+j]) begin
              rep_state[j] <= ST_WAIT;
              rep_cnt[j]   <= '0;
            end
          end
          ST_WAIT, ST_REPEAT: begin
            if (!deb[BTN_U+j]) begin
              rep_state[j] <= ST_IDLE;
              rep_cnt[j]   <= '0;
            end else if (rep_evt[j]) begin
              rep_state[j] <= ST_REPEAT;
              rep_cnt[j]   <= '0;
            end else begin
              rep_cnt[j] <= rep_cnt[j] + 1'b1;
            end
          end
          default: begin
            rep_state[j] <= ST_IDLE;
            rep_cnt[j]   <= '0;
          end
        endcase
      end
    end
  end

  assign up_evt   = press[BTN_U] | rep_evt[0];
  assign down_evt = press[BTN_D] | rep_evt[1];
`else
  assign up_evt   = press[BTN_U];
  assign down_evt = press[BTN_D];
`endif

  logic [IDX_W-1:0]   idx_p0;
  logic [IDX_W-1:0]   idx_nxt;
  logic [BLEND_W-1:0] blend_p0;
  logic [BLEND_W-1:0] blend_nxt;
  logic               img_chg_p0;
  logic               img_chg_p1;
  logic               blend_chg_p0;
  logic               blend_chg_p1;

  // Opposing requests in the same cycle cancel each other.
  always_comb begin
    idx_nxt = idx_p0;
    if (press[BTN_C] && !press[BTN_L])
      idx_nxt = (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
    else if (press[BTN_L] && !press[BTN_C])
      idx_nxt = (idx_p0 == '0) ? IDX_LAST : idx_p0 - 1'b1;

    blend_nxt = blend_p0;
    if (up_evt && !down_evt)
      blend_nxt = sat_blend($signed({2'b00, blend_p0}) + STEP_S);
    else if (down_evt && !up_evt)
      blend_nxt = sat_blend($signed({2'b00, blend_p0}) - STEP_S);
  end

  // Stage p0: value registers; p1: strobe lags the value by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0       <= '0;
      blend_p0     <= BLEND_W'(BLEND_INIT);
      img_chg_p0   <= 1'b0;
      img_chg_p1   <= 1'b0;
      blend_chg_p0 <= 1'b0;
      blend_chg_p1 <= 1'b0;
    end else begin
      idx_p0       <= idx_nxt;
      blend_p0     <= blend_nxt;
      img_chg_p0   <= (idx_nxt != idx_p0);
      img_chg_p1   <= img_chg_p0;
      blend_chg_p0 <= (blend_nxt != blend_p0);
      blend_chg_p1 <= blend_chg_p0;
    end
  end

  assign bus.image_index   = idx_p0;
  assign bus.blend_factor  = blend_p0;
  assign bus.image_changed = img_chg_p1;
  assign bus.blend_changed = blend_chg_p1;
endmodule

// File: tb/tb_user_input_ctrl.sv
// Randomised bench for user_input_ctrl: two instances (blend init 128 and 254) share the buttons
// and are compared every cycle against a history-window reference model.
module tb_user_input_ctrl;
  localparam int N_IMG = 5;
  localparam int DEB   = 4;
  localparam int RD    = 20;
  localparam int RR    = 5;
  localparam int STEP  = 1;
  localparam int BMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnc = 1'b0, btnl = 1'b0, btnu = 1'b0, btnd = 1'b0;

  always #5 clk = ~clk;

  user_input_ctrl_if #(.IDX_W(3), .BLEND_W(8)) if_a ();
  user_input_ctrl_if #(.IDX_W(3), .BLEND_W(8)) if_b ();

  assign if_a.btnc = btnc;
  assign if_a.btnl = btnl;
  assign if_a.btnu = btnu;
  assign if_a.btnd = btnd;
  assign if_b.btnc = btnc;
  assign if_b.btnl = btnl;
  assign if_b.btnu = btnu;
  assign if_b.btnd = btnd;

  user_input_ctrl #(.N_IMAGES(N_IMG), .BLEND_W(8), .BLEND_STEP(STEP), .BLEND_INIT(128),
                    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  user_input_ctrl #(.N_IMAGES(N_IMG), .BLEND_W(8), .BLEND_STEP(STEP), .BLEND_INIT(254),
                    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: a button's accepted level flips when the last DEB synchronised samples
  // (raw delayed by two clocks) all disagree with it.
  logic [15:0] rh [4];
  bit          mdeb [4];
  bit          fl [4];
  bit          pr [4];
  bit          rp [2];
  int          m_idx [2];
  int          m_blend [2];
  bit          m_ichg_p0 [2], m_ichg [2], m_bchg_p0 [2], m_bchg [2];
  int          init_v [2] = '{128, 254};
  int          cyc = 0;
  bit          nx, pv, up, dn, flip;
  int          ni, v;
  logic [3:0]  raw_s;
`ifdef AUTO_REPEAT_EN
  bit          rep_on [2];
  int          rep_t [2];
  int          h;
`endif

  always @(posedge clk) begin
    raw_s = {btnd, btnu, btnl, btnc};
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        rh[b]   = '0;
        mdeb[b] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        m_idx[k]     = 0;
        m_blend[k]   = init_v[k];
        m_ichg_p0[k] = 1'b0;
        m_ichg[k]    = 1'b0;
        m_bchg_p0[k] = 1'b0;
        m_bchg[k]    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_on[k]    = 1'b0;
`endif
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (rh[b][k] == mdeb[b]) flip = 1'b0;
        fl[b] = flip;
        pr[b] = flip && !mdeb[b];
      end
      rp[0] = 1'b0;
      rp[1] = 1'b0;
`ifdef AUTO_REPEAT_EN
      for (int j = 0; j < 2; j++) begin
        if (rep_on[j] && mdeb[2+j]) begin
          h = cyc - rep_t[j];
          if (h >= RD && ((h - RD) % RR) == 0) rp[j] = 1'b1;
        end
        if (!mdeb[2+j]) rep_on[j] = 1'b0;
        if (pr[2+j]) begin
          rep_on[j] = 1'b1;
          rep_t[j]  = cyc;
        end
      end
`endif
      for (int b = 0; b < 4; b++) begin
        if (fl[b]) mdeb[b] = !mdeb[b];
        rh[b] = {rh[b][14:0], raw_s[b]};
      end
      nx = pr[0];
      pv = pr[1];
      up = pr[2] | rp[0];
      dn = pr[3] | rp[1];
      for (int k = 0; k < 2; k++) begin
        m_ichg[k] = m_ichg_p0[k];
        m_bchg[k] = m_bchg_p0[k];
        ni = m_idx[k];
        if (nx && !pv)      ni = (ni + 1) % N_IMG;
        else if (pv && !nx) ni = (ni + N_IMG - 1) % N_IMG;
        m_ichg_p0[k] = (ni != m_idx[k]);
        m_idx[k] = ni;
        v = m_blend[k];
        if (up && !dn)      v = (v + STEP > BMAX) ? BMAX : v + STEP;
        else if (dn && !up) v = (v < STEP) ? 0 : v - STEP;
        m_bchg_p0[k] = (v != m_blend[k]);
        m_blend[k] = v;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    check("a_index",  int'(if_a.image_index),   m_idx[0]);
    check("a_blend",  int'(if_a.blend_factor),  m_blend[0]);
    check("a_img_st", int'(if_a.image_changed), int'(m_ichg[0]));
    check("a_bld_st", int'(if_a.blend_changed), int'(m_bchg[0]));
    check("b_index",  int'(if_b.image_index),   m_idx[1]);
    check("b_blend",  int'(if_b.blend_factor),  m_blend[1]);
    check("b_img_st", int'(if_b.image_changed), int'(m_ichg[1]));
    check("b_bld_st", int'(if_b.blend_changed), int'(m_bchg[1]));
  end

  bit count_en = 1'b0;
  int strobe_cnt = 0;
  always @(negedge clk) if (count_en && if_a.blend_changed) strobe_cnt++;

  task automatic drive(input logic [3:0] m, input int hold, input int gap);
    {btnd, btnu, btnl, btnc} = m;
    repeat (hold) @(negedge clk);
    {btnd, btnu, btnl, btnc} = 4'b0000;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int rc, hold;
    logic [3:0] m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_index", int'(if_a.image_index), 0);
    check("rst_blend", int'(if_a.blend_factor), 128);

    drive(4'b0001, 3, 10);                        // glitch, must be ignored
    check("glitch_index", int'(if_a.image_index), 0);
    drive(4'b0001, 10, 10);                       // clean next
    check("next_index", int'(if_a.image_index), 1);
    drive(4'b0010, 10, 10);
    drive(4'b0010, 10, 10);                       // prev from 0 wraps
    check("wrap_prev", int'(if_a.image_index), 4);
    for (int i = 0; i < 5; i++) drive(4'b0001, 10, 10);
    check("wrap_next", int'(if_a.image_index), 4);

    drive(4'b0100, 10, 10);
    drive(4'b0100, 10, 10);
    check("sat_hi", int'(if_b.blend_factor), 255);
    for (int i = 0; i < 135; i++) drive(4'b1000, 8, 10);
    check("sat_lo", int'(if_a.blend_factor), 0);
    drive(4'b1100, 10, 10);
    drive(4'b0011, 10, 10);

    count_en = 1'b1;
    drive(4'b0100, 42, 20);
    count_en = 1'b0;
`ifdef AUTO_REPEAT_EN
    check("repeat_cnt", strobe_cnt, 6);
`else
    check("repeat_cnt", strobe_cnt, 1);
`endif

    // Bouncy contacts: every button toggles at random.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 2) == 0) btnc = ~btnc;
      if ($urandom_range(0, 2) == 0) btnl = ~btnl;
      if ($urandom_range(0, 2) == 0) btnu = ~btnu;
      if ($urandom_range(0, 2) == 0) btnd = ~btnd;
      @(negedge clk);
    end
    drive(4'b0000, 0, 12);

    // Random presses with occasional reset mid-hold.
    for (int it = 0; it < 150; it++) begin
      m    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 45);
      rc   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hold - 1) : -1;
      {btnd, btnu, btnl, btnc} = m;
      for (int c = 0; c < hold; c++) begin
        if (c == rc) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      {btnd, btnu, btnl, btnc} = 4'b0000;
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
